// File: rtl/bool_diff_scanner_pkg.sv
// Shared types and width helpers for the Boolean-difference scanner.
//   state_e : scanner FSM states
//   pat_w   : pattern width W = 2N+1 ({Cin, A, B})
//   cnt_w   : hit counter width, wide enough to hold 2^W
package bool_diff_scanner_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StHold,
    StDone
  } state_e;

  function automatic int unsigned pat_w(input int unsigned n);
    return 2 * n + 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/bool_diff_scanner_if.sv
// Hit-pattern stream between the scanner and its sink.
//   pat_valid : pattern available (scanner -> sink)
//   pat_ready : sink accepts pattern (sink -> scanner)
//   pat_data  : hit pattern X = {Cin, A[N-1:0], B[N-1:0]}
interface bool_diff_scanner_if #(
  parameter int unsigned N = 4
) ();

  logic           pat_valid;
  logic           pat_ready;
  logic [2*N:0]   pat_data;

  modport master (
    output pat_valid,
    output pat_data,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pat_data,
    output pat_ready
  );

endinterface

// File: rtl/bool_diff_scanner_carry_eval.sv
// Combinational Boolean difference of the N-bit adder carry-out.
//   x       : pattern {Cin, A[N-1:0], B[N-1:0]}
//   var_idx : bit of x to differentiate on (values > 2N force nothing, diff = 0)
//   diff    : Cout(x | bit=0) ^ Cout(x | bit=1)
module bool_diff_scanner_carry_eval #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(2 * N + 1)
) (
  input  logic [2*N:0]     x,
  input  logic [SEL_W-1:0] var_idx,
  output logic             diff
);

  logic [2*N:0] x0;
  logic [2*N:0] x1;
  logic         c0;
  logic         c1;

  always_comb begin
    x0 = x;
    x1 = x;
    for (int i = 0; i < 2 * N + 1; i++) begin
      if (var_idx == SEL_W'(i)) begin
        x0[i] = 1'b0;
        x1[i] = 1'b1;
      end
    end
    // Ripple both cofactors: A at [2N-1:N], B at [N-1:0], Cin at [2N].
    c0 = x0[2*N];
    c1 = x1[2*N];
    for (int i = 0; i < N; i++) begin
      c0 = (x0[N+i] & x0[i]) | (c0 & (x0[N+i] ^ x0[i]));
      c1 = (x1[N+i] & x1[i]) | (c1 & (x1[N+i] ^ x1[i]));
    end
    diff = c0 ^ c1;
  end

endmodule

// File: rtl/bool_diff_scanner.sv
// Exhaustive Boolean-difference scanner for the N-bit adder carry-out.
// Walks X = 0 .. 2^(2N+1)-1 and streams every X where dCout/dX[var_sel] = 1.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a scan when idle; var_sel sampled with it
//   var_sel    : bit index of X to differentiate on
//   busy       : high in SCAN and HOLD
//   done       : one-cycle pulse at end of scan
//   err        : raised with done when var_sel > 2N; cleared by next start
//   hit_count  : hits in current/last scan
//   pat        : hit pattern stream (master side)
module bool_diff_scanner
  import bool_diff_scanner_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(2 * N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SEL_W-1:0]    var_sel,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2*N+1:0]      hit_count,
  bool_diff_scanner_if.master pat
);

  localparam int unsigned W  = pat_w(N);
  localparam int unsigned CW = cnt_w(N);

  // idx carries one spare bit so the terminal compare never depends on wrap.
  localparam logic [W:0]       LastIdx = {1'b0, {W{1'b1}}};
  localparam logic [SEL_W:0]   MaxVar  = (SEL_W + 1)'(2 * N);

  state_e           state_q;
  logic [W:0]       idx_q;
  logic [SEL_W-1:0] var_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             valid_q;
  logic [W-1:0]     data_q;
  logic [CW-1:0]    hit_q;

  logic             diff;
  logic             last;

  assign last = (idx_q == LastIdx);

  bool_diff_scanner_carry_eval #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_eval (
    .x       (idx_q[W-1:0]),
    .var_idx (var_q),
    .diff    (diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      var_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      hit_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            idx_q <= '0;
            hit_q <= '0;
            var_q <= var_sel;
            if ({1'b0, var_sel} > MaxVar) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= StScan;
            end
          end
        end
        StScan: begin
          if (diff) begin
            data_q  <= idx_q[W-1:0];
            valid_q <= 1'b1;
            hit_q   <= hit_q + CW'(1);
            state_q <= StHold;
          end else if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + (W + 1)'(1);
          end
        end
        StHold: begin
          if (pat.pat_ready) begin
            valid_q <= 1'b0;
            if (last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + (W + 1)'(1);
              state_q <= StScan;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign hit_count     = hit_q;
  assign pat.pat_valid = valid_q;
  assign pat.pat_data  = data_q;

endmodule

// File: tb/tb_bool_diff_scanner.sv
module tb_bool_diff_scanner;

  logic       clk;
  logic       rst_n;
  logic       start1;
  logic [1:0] var1;
  logic       busy1, done1, err1;
  logic [3:0] hits1;
  logic       start4;
  logic [3:0] var4;
  logic       busy4, done4, err4;
  logic [9:0] hits4;

  int checks;
  int failures;

  logic [8:0] exp_pat1[$];
  logic [8:0] exp_pat4[$];
  int         exp_hits1[$];
  int         exp_err1[$];
  int         exp_hits4[$];

  bool_diff_scanner_if #(.N(1)) if1 ();
  bool_diff_scanner_if #(.N(4)) if4 ();

  bool_diff_scanner #(.N(1)) u_n1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .var_sel   (var1),
    .busy      (busy1),
    .done      (done1),
    .err       (err1),
    .hit_count (hits1),
    .pat       (if1)
  );

  bool_diff_scanner #(.N(4)) u_n4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start4),
    .var_sel   (var4),
    .busy      (busy4),
    .done      (done4),
    .err       (err4),
    .hit_count (hits4),
    .pat       (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop on every accepted pattern and on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if1.pat_valid && if1.pat_ready) begin
        if (exp_pat1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL n1_pat_extra: got %0h expected none", if1.pat_data);
        end else begin
          check("n1_pat", int'(if1.pat_data), int'(exp_pat1.pop_front()));
        end
      end
      if (done1) begin
        check("n1_busy_at_done", int'(busy1), 0);
        check("n1_pats_left", exp_pat1.size(), 0);
        if (exp_hits1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL n1_done_extra: got done expected none");
        end else begin
          check("n1_hit_count", int'(hits1), exp_hits1.pop_front());
          check("n1_err", int'(err1), exp_err1.pop_front());
        end
      end
      if (if4.pat_valid && if4.pat_ready) begin
        if (exp_pat4.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL n4_pat_extra: got %0h expected none", if4.pat_data);
        end else begin
          check("n4_pat", int'(if4.pat_data), int'(exp_pat4.pop_front()));
        end
      end
      if (done4) begin
        check("n4_busy_at_done", int'(busy4), 0);
        check("n4_pats_left", exp_pat4.size(), 0);
        if (exp_hits4.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL n4_done_extra: got done expected none");
        end else begin
          check("n4_hit_count", int'(hits4), exp_hits4.pop_front());
          check("n4_err", int'(err4), 0);
        end
      end
    end
  end

  task automatic pulse_start1(input logic [1:0] v);
    @(posedge clk);
    #1;
    start1 = 1'b1;
    var1   = v;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic pulse_start4(input logic [3:0] v);
    @(posedge clk);
    #1;
    start4 = 1'b1;
    var4   = v;
    @(posedge clk);
    #1;
    start4 = 1'b0;
  endtask

  // Bounded wait for done; also checks the pulse is a single cycle.
  task automatic wait_done(input int which, input int budget, input string name);
    int  n;
    logic d;
    n = 0;
    forever begin
      @(negedge clk);
      d = (which == 1) ? done1 : done4;
      if (d) break;
      n++;
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        return;
      end
    end
    @(negedge clk);
    d = (which == 1) ? done1 : done4;
    check({name, "_done_width"}, int'(d), 0);
  endtask

  task automatic push_n1(input logic [8:0] a, b, c, d);
    exp_pat1.push_back(a);
    exp_pat1.push_back(b);
    exp_pat1.push_back(c);
    exp_pat1.push_back(d);
    exp_hits1.push_back(4);
    exp_err1.push_back(0);
  endtask

  // dCout/dCin = 1 exactly when A ^ B is all ones.
  task automatic push_n4_cin();
    logic [3:0] a;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 16; k++) begin
        a = 4'(k);
        exp_pat4.push_back({c[0], a, ~a});
      end
    end
    exp_hits4.push_back(32);
  endtask

  task automatic check_idle(input string name);
    check({name, "_n1_busy"}, int'(busy1), 0);
    check({name, "_n1_valid"}, int'(if1.pat_valid), 0);
    check({name, "_n1_hits"}, int'(hits1), 0);
    check({name, "_n4_busy"}, int'(busy4), 0);
    check({name, "_n4_done"}, int'(done4), 0);
    check({name, "_n4_err"}, int'(err4), 0);
    check({name, "_n4_valid"}, int'(if4.pat_valid), 0);
    check({name, "_n4_data"}, int'(if4.pat_data), 0);
    check({name, "_n4_hits"}, int'(hits4), 0);
  endtask

  initial begin
    int n;
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    start1       = 1'b0;
    var1         = '0;
    start4       = 1'b0;
    var4         = '0;
    if1.pat_ready = 1'b1;
    if4.pat_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // N=1, differentiate on Cin.
    push_n1(9'b001, 9'b010, 9'b101, 9'b110);
    pulse_start1(2'd2);
    @(negedge clk);
    check("n1_busy_in_scan", int'(busy1), 1);
    wait_done(1, 100, "n1_cin");

    // N=1, differentiate on B.
    push_n1(9'b010, 9'b011, 9'b100, 9'b101);
    pulse_start1(2'd0);
    wait_done(1, 100, "n1_b");

    // Out-of-range var: immediate done with err, no patterns.
    exp_hits1.push_back(0);
    exp_err1.push_back(1);
    pulse_start1(2'd3);
    wait_done(1, 20, "n1_err");
    check("n1_err_held", int'(err1), 1);

    // Next start clears err.
    push_n1(9'b001, 9'b010, 9'b101, 9'b110);
    pulse_start1(2'd2);
    @(negedge clk);
    check("n1_err_cleared", int'(err1), 0);
    wait_done(1, 100, "n1_clear");

    // Start while busy (with a different var) must not disturb the scan.
    push_n1(9'b001, 9'b010, 9'b101, 9'b110);
    pulse_start1(2'd2);
    repeat (2) @(posedge clk);
    pulse_start1(2'd0);
    wait_done(1, 100, "n1_restart");

    // N=4 Cin scan with the sink stalled on the first hit.
    push_n4_cin();
    if4.pat_ready = 1'b0;
    pulse_start4(4'd8);
    n = 0;
    forever begin
      @(negedge clk);
      if (if4.pat_valid) break;
      n++;
      if (n >= 100) begin
        checks++;
        failures++;
        $display("FAIL n4_first_hit_timeout: got no pat_valid expected one");
        break;
      end
    end
    for (int i = 0; i < 20; i++) begin
      check("n4_hold_data", int'(if4.pat_data), 9'h00F);
      check("n4_hold_valid", int'(if4.pat_valid), 1);
      check("n4_hold_hits", int'(hits4), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if4.pat_ready = 1'b1;
    wait_done(4, 2000, "n4_stall");

    // Abort mid-scan with reset; nothing is expected from the aborted scan.
    if4.pat_ready = 1'b0;
    pulse_start4(4'd8);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_abort");

    if4.pat_ready = 1'b1;
    push_n4_cin();
    pulse_start4(4'd8);
    wait_done(4, 2000, "n4_rescan");

    repeat (3) @(posedge clk);
    check("n1_done_left", exp_hits1.size(), 0);
    check("n4_done_left", exp_hits4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
